// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode field, and fetch-state encoding.
package cpu_pkg;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 19;
    localparam int OPC_HI  = 18;
    localparam int OPC_LO  = 14;
    localparam int CNT_W   = 16;

    localparam logic [OPC_HI-OPC_LO:0] HALT_OPC  = 5'b11111;
    localparam logic [INSTR_W-1:0]     NOP_INSTR = '0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: hazard/branch controls, imem port, IF/ID write side.
interface if_fetch_unit_if;
    import cpu_pkg::*;

    logic               pc_write;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] next_instruction;
    logic [PC_W-1:0]    pc_plus_one_IF;
    logic               IF_IDwrite;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        output pc_write, branch_taken, branch_target, imem_data,
        input  imem_addr, next_instruction, pc_plus_one_IF,
        input  IF_IDwrite, halted, fetch_count
    );

    modport slave (
        input  pc_write, branch_taken, branch_target, imem_data,
        output imem_addr, next_instruction, pc_plus_one_IF,
        output IF_IDwrite, halted, fetch_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, redirect/flush, stall, HALT parking, IF/ID write.
module if_fetch_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    if_fetch_unit_if.slave bus
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            is_halt;
    logic            cnt_inc;

    assign pc_inc  = pc_q + PC_W'(1);
    assign is_halt = (bus.imem_data[OPC_HI:OPC_LO] == HALT_OPC);

    // Branch beats stall: the word sitting in ID is wrong-path either way.
    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        cnt_inc              = 1'b0;
        bus.IF_IDwrite       = 1'b1;
        bus.next_instruction = bus.imem_data;
        unique case (state_q)
            RUN: begin
                if (bus.branch_taken) begin
                    bus.next_instruction = NOP_INSTR;
                    pc_d                 = bus.branch_target;
                end else if (!bus.pc_write) begin
                    bus.IF_IDwrite = 1'b0;
                end else if (is_halt) begin
                    cnt_inc = 1'b1;
                    state_d = HALTED;
                end else begin
                    cnt_inc = 1'b1;
                    pc_d    = pc_inc;
                end
            end
            HALTED: begin
                bus.next_instruction = NOP_INSTR;
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (cnt_inc),
        .count_o (bus.fetch_count)
    );

    assign bus.imem_addr      = pc_q;
    assign bus.pc_plus_one_IF = pc_inc;
    assign bus.halted         = (state_q == HALTED);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector table plus hand sequences for the fetch stage.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic         pw;
        logic         bt;
        logic [7:0]   tgt;
        logic [7:0]   addr;
        logic         wr;
        logic [18:0]  instr;
        logic [7:0]   pp1;
        logic         hlt;
        logic [15:0]  cnt;
    } vec_t;

    localparam logic [18:0] HALT_WORD = 19'h7C003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [18:0] imem [256];
    vec_t vq[$];
    int total = 0;
    int bad = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = imem[bus.imem_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pw, input logic bt, input logic [7:0] tgt,
                       input logic [7:0] addr, input logic wr,
                       input logic [18:0] instr, input logic [7:0] pp1,
                       input logic hlt, input logic [15:0] cnt);
        vec_t v;
        v.pw = pw; v.bt = bt; v.tgt = tgt; v.addr = addr; v.wr = wr;
        v.instr = instr; v.pp1 = pp1; v.hlt = hlt; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic pw, input logic bt, input logic [7:0] tgt);
        @(negedge clk);
        bus.pc_write      = pw;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.pc_write = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.pc_write = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        for (int i = 0; i < 256; i++) imem[i] = 19'(i);
        imem[3] = HALT_WORD;

        //  pw bt tgt    addr wr instr      pp1   h  cnt
        add(1, 0, 8'h00, 8'h00, 1, 19'h0, 8'h01, 0, 16'd0);
        add(1, 0, 8'h00, 8'h01, 1, 19'h1, 8'h02, 0, 16'd1);
        add(1, 0, 8'h00, 8'h02, 1, 19'h2, 8'h03, 0, 16'd2);
        add(1, 0, 8'h00, 8'h03, 1, HALT_WORD, 8'h04, 0, 16'd3);
        for (int i = 0; i < 10; i++)
            add(i[0], 0, 8'h00, 8'h03, 1, 19'h0, 8'h04, 1, 16'd4);
        add(1, 1, 8'h05, 8'h03, 1, 19'h0, 8'h04, 1, 16'd4);
        add(0, 0, 8'h00, 8'h05, 0, 19'h5, 8'h06, 0, 16'd4);
        add(0, 0, 8'h00, 8'h05, 0, 19'h5, 8'h06, 0, 16'd4);
        add(1, 0, 8'h00, 8'h05, 1, 19'h5, 8'h06, 0, 16'd4);
        add(1, 0, 8'h00, 8'h06, 1, 19'h6, 8'h07, 0, 16'd5);
        add(0, 1, 8'h40, 8'h07, 1, 19'h0, 8'h08, 0, 16'd6);
        add(1, 0, 8'h00, 8'h40, 1, 19'h40, 8'h41, 0, 16'd6);
        add(1, 1, 8'hFF, 8'h41, 1, 19'h0, 8'h42, 0, 16'd7);
        add(1, 0, 8'h00, 8'hFF, 1, 19'hFF, 8'h00, 0, 16'd7);
        add(1, 0, 8'h00, 8'h00, 1, 19'h0, 8'h01, 0, 16'd8);
        add(1, 1, 8'h10, 8'h01, 1, 19'h0, 8'h02, 0, 16'd9);
        add(0, 0, 8'h00, 8'h10, 0, 19'h10, 8'h11, 0, 16'd9);

        do_reset();
        #1;
        chk("reset_addr", 32'(bus.imem_addr), 32'h0);
        chk("reset_cnt", 32'(bus.fetch_count), 32'h0);
        chk("reset_halted", 32'(bus.halted), 32'h0);

        foreach (vq[k]) begin
            if (k != 0) @(negedge clk);
            bus.pc_write      = vq[k].pw;
            bus.branch_taken  = vq[k].bt;
            bus.branch_target = vq[k].tgt;
            #1;
            chk($sformatf("v%0d_addr", k), 32'(bus.imem_addr), 32'(vq[k].addr));
            chk($sformatf("v%0d_wr", k), 32'(bus.IF_IDwrite), 32'(vq[k].wr));
            if (vq[k].wr)
                chk($sformatf("v%0d_instr", k), 32'(bus.next_instruction),
                    32'(vq[k].instr));
            chk($sformatf("v%0d_pp1", k), 32'(bus.pc_plus_one_IF), 32'(vq[k].pp1));
            chk($sformatf("v%0d_halted", k), 32'(bus.halted), 32'(vq[k].hlt));
            chk($sformatf("v%0d_cnt", k), 32'(bus.fetch_count), 32'(vq[k].cnt));
        end

        // Saturation: remove the HALT so the PC free-runs through every word.
        imem[3] = 19'h3;
        do_reset();
        repeat (65540) @(posedge clk);
        @(negedge clk); #1;
        chk("sat_cnt", 32'(bus.fetch_count), 32'hFFFF);
        chk("sat_halted", 32'(bus.halted), 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("sat_hold", 32'(bus.fetch_count), 32'hFFFF);

        // Park on HALT at 3, then resume from HALTED via branch to 0x10.
        imem[3] = HALT_WORD;
        drive(1, 1, 8'h03);
        drive(1, 0, 8'h00);
        begin
            int n;
            n = 0;
            while (!bus.halted && n < 5) begin
                @(negedge clk);
                n++;
            end
            #1;
            chk("halt_reached", 32'(bus.halted), 32'h1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("halt_addr", 32'(bus.imem_addr), 32'h3);
        chk("halt_nop", 32'(bus.next_instruction), 32'h0);
        chk("halt_cnt", 32'(bus.fetch_count), 32'hFFFF);
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h10;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        #1;
        chk("resume_addr", 32'(bus.imem_addr), 32'h10);
        chk("resume_halted", 32'(bus.halted), 32'h0);
        chk("resume_instr", 32'(bus.next_instruction), 32'h10);

        // Reset while HALTED.
        drive(1, 1, 8'h03);
        drive(1, 0, 8'h00);
        @(negedge clk); #1;
        chk("halt2", 32'(bus.halted), 32'h1);
        do_reset();
        #1;
        chk("rst_halt_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_halt_cnt", 32'(bus.fetch_count), 32'h0);
        chk("rst_halt_halted", 32'(bus.halted), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage and sole writer of the IF/ID pipeline register. Owns the 8-bit PC, addresses the 256x19 instruction memory, and drives next_instruction, pc_plus_one_IF and IF_IDwrite into IF/ID. It honours stalls from the hazard unit, applies branch redirects with a one-slot flush (NOP injection), and parks the front end on a fetched HALT. Also keeps a saturating count of instructions issued into IF/ID.

Parameters:
PC_W, 8, PC and instruction-address width
INSTR_W, 19, instruction width
OPC_HI, 18, MSB of opcode field
OPC_LO, 14, LSB of opcode field
HALT_OPC, 5'b11111, opcode that halts fetch
NOP_INSTR, 19'b0, instruction injected on flush or halt
CNT_W, 16, fetch counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
pc_write  in  1  from hazard unit; 1 = advance, 0 = stall (hold PC and IF/ID)
branch_taken  in  1  redirect request from the resolving stage
branch_target  in  PC_W  redirect address, valid with branch_taken
imem_data  in  INSTR_W  combinational read data for imem_addr
imem_addr  out  PC_W  instruction-memory address (= PC)
next_instruction  out  INSTR_W  to IF/ID instruction input
pc_plus_one_IF  out  PC_W  to IF/ID PC+1 input
IF_IDwrite  out  1  to IF/ID write enable
halted  out  1  1 while in HALTED state
fetch_count  out  CNT_W  real instructions written into IF/ID, saturating

Behaviour:
- Reset (rst=1 at posedge): pc<=0, state<=RUN, fetch_count<=0. Reset dominates all other inputs.
- Combinational outputs: imem_addr=pc; pc_plus_one_IF=pc+1 mod 256 (0xFF->0x00).
- States: RUN, HALTED. Per-cycle priority: rst > branch_taken > !pc_write (stall) > HALT detect > normal.
- RUN, branch_taken=1: flush. next_instruction=NOP_INSTR, IF_IDwrite=1, pc<=branch_target, state RUN. Count unchanged. Overrides a concurrent stall, since the ID instruction is wrong-path.
- RUN, stall (pc_write=0, no branch): IF_IDwrite=0, pc holds, count holds. next_instruction=imem_data, a don't-care because not written.
- RUN, fetched opcode (imem_data[OPC_HI:OPC_LO]) == HALT_OPC, no stall/branch: IF_IDwrite=1, next_instruction=imem_data (HALT goes down the pipe), pc holds, count+1, state<=HALTED.
- RUN, normal: IF_IDwrite=1, next_instruction=imem_data, pc<=pc+1 with wrap, count+1.
- HALTED: IF_IDwrite=1, next_instruction=NOP_INSTR, pc holds, count holds, halted=1. pc_write is ignored.
- HALTED, branch_taken=1: the HALT was wrong-path. Inject NOP, pc<=branch_target, state<=RUN, halted falls next cycle.
- fetch_count saturates at 0xFFFF and never wraps.
- Latency: an instruction at address A appears at IF/ID output one posedge after imem_addr=A with no stall.
- Reset mid-stall or while HALTED: next cycle is RUN at pc=0 with count 0.

Decomposition:
- Shared package cpu_pkg: INSTR_W, PC_W, opcode field bounds, HALT_OPC, NOP_INSTR, and the fetch state enum (RUN, HALTED).
- One natural sub-module: sat_counter (CNT_W, inc, rst -> saturating value), reusable for other performance counters.
- PC register, next-PC mux and FSM stay inline.

Test Plan:
- Reset then free run, imem[i]=i for i<3 (opcode 0): IF_IDwrite=1 every cycle, next_instruction 0,1,2 on successive cycles, pc_plus_one_IF 1,2,3, fetch_count=3 after 3 cycles.
- pc_write=0 for 2 cycles at pc=5: IF_IDwrite=0, imem_addr stays 5, count frozen. On release, instruction at 5 is issued and pc becomes 6.
- branch_taken=1, branch_target=0x40, with pc_write=0 at pc=7: next_instruction=0, IF_IDwrite=1, next imem_addr=0x40, count unchanged.
- pc=0xFF with normal fetch: pc_plus_one_IF=0x00 and next imem_addr=0x00.
- imem[3] opcode 5'b11111: the HALT word is written once, then halted=1, IF_IDwrite=1 with NOP each cycle, and imem_addr stays 3 for 10+ cycles. A later branch_taken to 0x10 resumes RUN at 0x10.
- Preload fetch_count near max via 65 540 run cycles (imem all opcode 0): fetch_count holds at 0xFFFF. rst=1 while HALTED: pc=0, count=0, halted=0 next cycle.
